// File: rtl/rpm_pkg.sv
// Shared constants and FSM encoding for the RPM sample scheduler.
// RPM = delta_counts * RPM_NUM / RPM_DEN, saturated to a signed 16-bit range.
package rpm_pkg;

    localparam int RPM_NUM = 3125;
    localparam int RPM_DEN = 10000;
    localparam int PW      = 46;
    localparam int REM_W   = 14;
    localparam int RPM_MAX = 32767;
    localparam int RPM_MIN = -32768;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIFF,
        S_MUL,
        S_DIV,
        S_STORE,
        S_COMMIT
    } state_e;

endpackage

// File: rtl/rpm_div_seq.sv
// Restoring unsigned divider by the fixed constant RPM_DEN, one quotient bit per cycle.
// The first iteration runs in the start cycle; done pulses W cycles after start.
module rpm_div_seq
    import rpm_pkg::*;
#(
    parameter int W = PW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    output logic [W-1:0] quotient,
    output logic         done
);

    localparam int CW = $clog2(W + 1);
    localparam logic [REM_W:0] DEN = (REM_W + 1)'(RPM_DEN);

    logic [W-1:0]     work_q, work_d, src;
    logic [REM_W-1:0] rem_q, rem_d, rem_src;
    logic [REM_W:0]   trial;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d, load;

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        load    = start && !busy_q;
        src     = load ? dividend : work_q;
        rem_src = load ? '0 : rem_q;
        trial   = {rem_src, src[W-1]};
        work_d  = work_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (load || busy_q) begin
            // work_q shifts dividend bits out the top while quotient bits enter at the bottom.
            if (trial >= DEN) begin
                rem_d  = REM_W'(trial - DEN);
                work_d = {src[W-2:0], 1'b1};
            end else begin
                rem_d  = trial[REM_W-1:0];
                work_d = {src[W-2:0], 1'b0};
            end
            if (load) begin
                cnt_d  = CW'(1);
                busy_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses <= so every flop updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            work_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            work_q <= work_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quotient = work_q;
    assign done     = done_q;

endmodule

// File: rtl/rpm_sample_sched.sv
// Periodic snapshot of all encoder counts, walked channel by channel through one
// shared subtract / multiply / divide path, with an atomic publish of all RPM values.
module rpm_sample_sched
    import rpm_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int PERIOD = 250000,
    parameter int CNT_W  = 33,
    parameter int RPM_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear_flags,
    input  logic [N_CH*CNT_W-1:0] count_flat,
    output logic [N_CH*RPM_W-1:0] rpm_flat,
    output logic                  rpm_valid,
    output logic                  sample_tick,
    output logic                  busy,
    output logic                  overrun,
    output logic [N_CH-1:0]       sat_flags
);

    localparam int MW   = CNT_W + 13;
    localparam int PS_W = $clog2(PERIOD);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_e                  state_q, state_d;
    logic [PS_W-1:0]         ps_q, ps_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic                    en_prev_q, prime_pend_q, prime_pend_d, priming_q, priming_d;
    logic                    overrun_q, overrun_d;
    logic [N_CH-1:0]         sat_q, sat_d;
    logic signed [CNT_W-1:0] snap_q [N_CH], snap_d [N_CH];
    logic signed [CNT_W-1:0] last_q [N_CH], last_d [N_CH];
    logic signed [RPM_W-1:0] shadow_q [N_CH], shadow_d [N_CH];
    logic [CNT_W:0]          abs_q, abs_d;
    logic                    neg_q, neg_d;
    logic [N_CH*RPM_W-1:0]   rpm_q, rpm_d;
    logic signed [CNT_W:0]   delta;
    logic [MW-1:0]           mag, div_q;
    logic signed [RPM_W-1:0] store_val;
    logic                    store_sat, tick, accept, last_ch, div_start, div_done;

    assign tick    = enable && (ps_q == PS_W'(PERIOD - 1));
    assign accept  = tick && (state_q == S_IDLE);
    assign last_ch = (ch_q == CH_W'(N_CH - 1));

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_DIFF;
            S_DIFF:   if (!priming_q) state_d = S_MUL;
                      else if (last_ch) state_d = S_IDLE;
            S_MUL:    state_d = S_DIV;
            S_DIV:    if (div_done) state_d = S_STORE;
            S_STORE:  state_d = last_ch ? S_COMMIT : S_DIFF;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        sample_tick = accept;
        rpm_valid   = (state_q == S_COMMIT);
        div_start   = (state_q == S_MUL);
    end

    always_comb begin
        ps_d         = (!enable || ps_q == PS_W'(PERIOD - 1)) ? '0 : ps_q + PS_W'(1);
        prime_pend_d = (accept ? 1'b0 : prime_pend_q) || (enable && !en_prev_q);
        priming_d    = accept ? prime_pend_q : priming_q;
        overrun_d    = (clear_flags ? 1'b0 : overrun_q) || (tick && state_q != S_IDLE);
        sat_d        = clear_flags ? '0 : sat_q;
        ch_d         = ch_q;
        snap_d       = snap_q;
        last_d       = last_q;
        shadow_d     = shadow_q;
        abs_d        = abs_q;
        neg_d        = neg_q;
        rpm_d        = rpm_q;
        delta        = {snap_q[ch_q][CNT_W-1], snap_q[ch_q]} - {last_q[ch_q][CNT_W-1], last_q[ch_q]};
        mag          = MW'(abs_q) * MW'(RPM_NUM);
        if (neg_q) begin
            store_sat = (div_q > MW'(-RPM_MIN));
            store_val = store_sat ? RPM_W'(RPM_MIN) : -RPM_W'(div_q);
        end else begin
            store_sat = (div_q > MW'(RPM_MAX));
            store_val = store_sat ? RPM_W'(RPM_MAX) : RPM_W'(div_q);
        end

        if (accept) begin
            ch_d = '0;
            for (int i = 0; i < N_CH; i++) snap_d[i] = count_flat[i*CNT_W +: CNT_W];
        end
        if (state_q == S_DIFF) begin
            last_d[ch_q] = snap_q[ch_q];
            neg_d        = delta[CNT_W];
            abs_d        = delta[CNT_W] ? -delta : delta;
            if (priming_q && !last_ch) ch_d = ch_q + CH_W'(1);
        end
        if (state_q == S_STORE) begin
            shadow_d[ch_q] = store_val;
            if (store_sat) sat_d[ch_q] = 1'b1;
            if (!last_ch) ch_d = ch_q + CH_W'(1);
            // Publish on entry to COMMIT so rpm_flat is already new while rpm_valid is high.
            else for (int i = 0; i < N_CH; i++) rpm_d[i*RPM_W +: RPM_W] = shadow_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q         <= '0;
            ch_q         <= '0;
            en_prev_q    <= 1'b0;
            prime_pend_q <= 1'b1;
            priming_q    <= 1'b0;
            overrun_q    <= 1'b0;
            sat_q        <= '0;
            last_q       <= '{default: '0};
            abs_q        <= '0;
            neg_q        <= 1'b0;
            rpm_q        <= '0;
        end else begin
            ps_q         <= ps_d;
            ch_q         <= ch_d;
            en_prev_q    <= enable;
            prime_pend_q <= prime_pend_d;
            priming_q    <= priming_d;
            overrun_q    <= overrun_d;
            sat_q        <= sat_d;
            last_q       <= last_d;
            abs_q        <= abs_d;
            neg_q        <= neg_d;
            rpm_q        <= rpm_d;
        end
    end

    // NOTE: snapshot and shadow storage carry no reset; each entry is written before it is read.
    always_ff @(posedge clk) begin
        snap_q   <= snap_d;
        shadow_q <= shadow_d;
    end

    rpm_div_seq #(.W(MW)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (mag),
        .quotient (div_q),
        .done     (div_done)
    );

    assign rpm_flat  = rpm_q;
    assign overrun   = overrun_q;
    assign sat_flags = sat_q;

endmodule

// File: tb/tb_rpm_sample_sched.sv
// Directed bench for rpm_sample_sched: expected RPM vectors are queued at each accepted
// tick and compared, along with their arrival cycle, when rpm_valid pulses.
module tb_rpm_sample_sched;

    localparam int     N_CH   = 4;
    localparam int     PERIOD = 150;
    localparam int     CNT_W  = 33;
    localparam int     RPM_W  = 16;
    localparam longint SEQ    = 49 * N_CH + 1;

    logic                  clk = 1'b0;
    logic                  reset, enable, clear_flags;
    logic [N_CH*CNT_W-1:0] count_flat;
    logic [N_CH*RPM_W-1:0] rpm_flat;
    logic                  rpm_valid, sample_tick, busy, overrun;
    logic [N_CH-1:0]       sat_flags;

    typedef struct {
        longint                at;
        logic [N_CH*RPM_W-1:0] rpm;
    } exp_t;

    exp_t            sb[$];
    exp_t            mon_e;
    int              checks = 0;
    int              errors = 0;
    longint          cyc = 0;
    longint          cur[N_CH];
    longint          prev[N_CH];
    bit              prime;
    logic [N_CH-1:0] exp_sat;
    longint          t, rel;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rpm_sample_sched #(
        .N_CH   (N_CH),
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W),
        .RPM_W  (RPM_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .clear_flags (clear_flags),
        .count_flat  (count_flat),
        .rpm_flat    (rpm_flat),
        .rpm_valid   (rpm_valid),
        .sample_tick (sample_tick),
        .busy        (busy),
        .overrun     (overrun),
        .sat_flags   (sat_flags)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: truncation toward zero, then clamp to the signed 16-bit range.
    function automatic void model(input longint d, output logic [RPM_W-1:0] v, output logic s);
        longint q;
        q = (d * 3125) / 10000;
        s = 1'b0;
        if (q > 32767) begin
            q = 32767;
            s = 1'b1;
        end else if (q < -32768) begin
            q = -32768;
            s = 1'b1;
        end
        v = q[RPM_W-1:0];
    endfunction

    task automatic set_counts(input longint c0, input longint c1, input longint c2, input longint c3);
        cur[0] = c0;
        cur[1] = c1;
        cur[2] = c2;
        cur[3] = c3;
        for (int i = 0; i < N_CH; i++) count_flat[i*CNT_W +: CNT_W] = cur[i][CNT_W-1:0];
    endtask

    task automatic step_counts(input longint d0, input longint d1, input longint d2, input longint d3);
        set_counts(cur[0] + d0, cur[1] + d1, cur[2] + d2, cur[3] + d3);
    endtask

    // Waits for the next accepted tick, checks its cycle, queues the expected result,
    // and returns one cycle later so the snapshot edge has passed.
    task automatic wait_tick(input longint exp_at);
        exp_t             e;
        logic [RPM_W-1:0] v;
        logic             s;
        t = -1;
        for (int n = 0; n < 4 * PERIOD && t < 0; n++) begin
            @(negedge clk);
            if (sample_tick) t = cyc;
        end
        check("tick_cycle", t, exp_at);
        if (prime) begin
            prime = 1'b0;
        end else begin
            e.at  = t + SEQ;
            e.rpm = '0;
            for (int i = 0; i < N_CH; i++) begin
                model(cur[i] - prev[i], v, s);
                e.rpm[i*RPM_W +: RPM_W] = v;
                if (s) exp_sat[i] = 1'b1;
            end
            sb.push_back(e);
        end
        prev = cur;
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        exp_sat     = '0;
    endtask

    task automatic drain();
        for (int n = 0; n < 2 * SEQ && sb.size() != 0; n++) @(negedge clk);
        check("drain", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rpm_valid) begin
            check("valid_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("valid_cycle", cyc, mon_e.at);
                check("rpm_flat", rpm_flat, mon_e.rpm);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        enable      = 1'b1;
        clear_flags = 1'b0;
        prime       = 1'b1;
        exp_sat     = '0;
        for (int i = 0; i < N_CH; i++) prev[i] = 0;
        set_counts(1000, 1000, 1000, 1000);
        repeat (3) @(negedge clk);
        check("rst_rpm_flat", rpm_flat, 0);
        check("rst_rpm_valid", rpm_valid, 0);
        check("rst_sample_tick", sample_tick, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_sat_flags", sat_flags, 0);
        reset = 1'b0;
        rel   = cyc;

        // Priming tick: DIFF-only walk, no publish.
        wait_tick(rel + PERIOD - 1);
        check("prime_busy", busy, 1);
        repeat (N_CH - 1) @(negedge clk);
        check("prime_busy_last", busy, 1);
        @(negedge clk);
        check("prime_idle", busy, 0);

        // Constant counts give zero RPM; exact commit timing.
        wait_tick(t + PERIOD);
        check("seq_busy", busy, 1);
        repeat (SEQ - 1) @(negedge clk);
        check("busy_at_commit", busy, 1);
        check("valid_at_commit", rpm_valid, 1);
        @(negedge clk);
        check("busy_after_commit", busy, 0);
        check("valid_after_commit", rpm_valid, 0);

        // Previous sequence still running at t+PERIOD, so that tick is dropped.
        wait_tick(t + 2 * PERIOD);
        check("overrun_set", overrun, 1);
        pulse_clear();
        check("overrun_clr", overrun, 0);
        check("sat_clr", sat_flags, 0);
        step_counts(10000, -640, 7, -7);

        wait_tick(t + 2 * PERIOD);
        step_counts(200000, 0, 0, 0);

        wait_tick(t + 2 * PERIOD);
        step_counts(-200000, 100, -100, 0);
        drain();
        check("sat_pos", sat_flags, exp_sat);

        wait_tick(t + 2 * PERIOD);
        step_counts(104857, -104858, 104858, -104861);
        drain();
        check("sat_sticky", sat_flags, exp_sat);
        pulse_clear();
        check("sat_clear", sat_flags, 0);
        check("overrun_clear2", overrun, 0);

        // Boundaries: 32767 and -32768 exact (no flag), one past each saturates.
        wait_tick(t + 2 * PERIOD);
        step_counts(5, 5, 5, 5);
        drain();
        check("sat_boundary", sat_flags, exp_sat);

        // Reset in the middle of a sequence discards the in-flight result.
        wait_tick(t + 2 * PERIOD);
        repeat (99) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        sb.delete(sb.size() - 1);
        check("midrst_busy", busy, 0);
        check("midrst_rpm_flat", rpm_flat, 0);
        check("midrst_sat", sat_flags, 0);
        check("midrst_overrun", overrun, 0);
        reset   = 1'b0;
        rel     = cyc;
        prime   = 1'b1;
        exp_sat = '0;
        set_counts(50000, -50000, 123456, 0);
        wait_tick(rel + PERIOD - 1);
        step_counts(3200, -3200, 32, 0);

        // Enable drops mid-sequence: sequence completes, prescaler restarts, next tick primes.
        wait_tick(t + PERIOD);
        step_counts(1, 2, 3, 4);
        repeat (49) @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        enable = 1'b1;
        rel    = cyc;
        prime  = 1'b1;
        wait_tick(rel + PERIOD - 1);
        step_counts(-3200, 3200, 0, 64);
        wait_tick(t + PERIOD);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
